// File: rtl/ht_ltf_seq_pkg.sv
// ht_ltf_seq_pkg: shared types, constants and sample helpers for the HT-LTF sequencer.
//   - seq_state_e : sequencer FSM states
//   - SymLenDefault, PRow, sample field slice positions
//   - neg_sat16 / apply_sign : saturating sample negation
//   - nltf_legal / nltf_to_nm1 : repetition-count decoding
package ht_ltf_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StFetch,
    StPlay,
    StDone
  } seq_state_e;

  localparam int unsigned SymLenDefault = 80;
  localparam int unsigned SampleW       = 32;

  // Single-stream P-matrix row, one bit per repetition; a set bit negates.
  localparam logic [3:0] PRow = 4'b0010;

  // {I, Q} packing of a complex sample.
  localparam int unsigned IMsb = 31;
  localparam int unsigned ILsb = 16;
  localparam int unsigned QMsb = 15;
  localparam int unsigned QLsb = 0;

  // Two's-complement negate; -32768 has no positive twin so it clips to 32767.
  function automatic logic [15:0] neg_sat16(input logic [15:0] x);
    return (x == 16'h8000) ? 16'h7fff : (16'h0000 - x);
  endfunction

  function automatic logic [SampleW-1:0] apply_sign(input logic [SampleW-1:0] s,
                                                    input logic             neg);
    if (!neg) begin
      return s;
    end
    return {neg_sat16(s[IMsb:ILsb]), neg_sat16(s[QMsb:QLsb])};
  endfunction

  function automatic logic nltf_legal(input logic [2:0] n);
    return (n == 3'd1) || (n == 3'd2) || (n == 3'd4);
  endfunction

  // Stored as count-1 so the last repetition index fits in two bits; illegal maps to 1 rep.
  function automatic logic [1:0] nltf_to_nm1(input logic [2:0] n);
    case (n)
      3'd2:    return 2'd1;
      3'd4:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ht_ltf_sequencer_if.sv
// ht_ltf_sequencer_if: valid/ready sample stream toward the preamble/data mux.
//   tdata  : {I[31:16], Q[15:0]} signed sample
//   tvalid : sample valid
//   tready : downstream ready
//   tlast  : final sample of the final repetition
// Modports: master (sequencer side), slave (consumer side).
interface ht_ltf_sequencer_if;
  import ht_ltf_seq_pkg::*;

  logic [SampleW-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/ht_ltf_sequencer_ltf_sym_buf.sv
// ltf_sym_buf: simple dual-port Depth x Width symbol buffer.
//   clk_i                       : clock
//   wr_en_i/wr_addr_i/wr_data_i : write port
//   rd_en_i/rd_addr_i           : read request; rd_data_o valid the following cycle
//   rd_data_o                   : registered read data, held while rd_en_i is low
module ltf_sym_buf #(
  parameter int unsigned Depth = 80,
  parameter int unsigned Width = 32,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ht_ltf_sequencer.sv
// ht_ltf_sequencer: captures one HT-LTF symbol from the time-domain generator and replays it
// n_ltf times (1, 2 or 4) with the single-stream P-matrix sign per repetition.
//   clk, rstn          : clock, asynchronous active-low reset
//   start, n_ltf       : sequence start pulse and repetition count (sampled on start)
//   busy, done, err    : status; err is sticky until the next accepted start
//   gen_letsgo         : request pulse to the generator
//   gen_givemeoutput   : readout pulse to the generator
//   gen_output_valid   : generator has a symbol ready
//   gen_ltf            : generator sample stream
//   m                  : valid/ready output stream (master modport)
// Optional feature macro HT_LTF_SEQ_TIMEOUT_EN: abort with err after TIMEOUT cycles in REQ.
module ht_ltf_sequencer
  import ht_ltf_seq_pkg::*;
#(
  parameter int unsigned SYM_LEN     = SymLenDefault,
  parameter int unsigned CAPTURE_DLY = 2
`ifdef HT_LTF_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT     = 1024
`endif
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [2:0]          n_ltf,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                gen_letsgo,
  output logic                gen_givemeoutput,
  input  logic                gen_output_valid,
  input  logic [SampleW-1:0]  gen_ltf,
  ht_ltf_sequencer_if.master  m
);

  localparam int unsigned AddrW = $clog2(SYM_LEN);
  localparam int unsigned CntW  = $clog2(CAPTURE_DLY + SYM_LEN);

  localparam logic [CntW-1:0]  CapFirst = CntW'(CAPTURE_DLY);
  localparam logic [CntW-1:0]  CapLast  = CntW'(CAPTURE_DLY + SYM_LEN - 1);
  localparam logic [AddrW-1:0] AddrLast = AddrW'(SYM_LEN - 1);

`ifdef HT_LTF_SEQ_TIMEOUT_EN
  localparam int unsigned     TmoW    = $clog2(TIMEOUT);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  logic [TmoW-1:0] tmo_q;
`endif

  seq_state_e         state_q;
  logic [1:0]         nm1_q;
  logic [CntW-1:0]    cnt_q;
  // Issue side: next buffer read (repetition, address) and whether all reads are issued.
  logic [1:0]         rep_q;
  logic [AddrW-1:0]   rd_addr_q;
  logic               issue_done_q;
  // Tags travelling alongside the registered buffer output.
  logic               v1_q;
  logic [1:0]         rep1_q;
  logic               last1_q;

  logic               busy_q, done_q, err_q, letsgo_q, give_q;
  logic [SampleW-1:0] tdata_q;
  logic               tvalid_q, tlast_q;

  logic               wr_en;
  logic [AddrW-1:0]   wr_addr;
  logic               rd_en;
  logic [SampleW-1:0] rd_data;
  logic               issue_last;

  always_comb begin
    wr_en      = (state_q == StFetch) && (cnt_q >= CapFirst);
    wr_addr    = AddrW'(cnt_q - CapFirst);
    // Buffer output and output register advance together, so a stall freezes both stages.
    rd_en      = (state_q == StPlay) && (!tvalid_q || m.tready);
    issue_last = (rep_q == nm1_q) && (rd_addr_q == AddrLast);
  end

  ltf_sym_buf #(
    .Depth (SYM_LEN),
    .Width (SampleW),
    .AddrW (AddrW)
  ) u_buf (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (gen_ltf),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr_q),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      nm1_q        <= '0;
      cnt_q        <= '0;
      rep_q        <= '0;
      rd_addr_q    <= '0;
      issue_done_q <= 1'b0;
      v1_q         <= 1'b0;
      rep1_q       <= '0;
      last1_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      letsgo_q     <= 1'b0;
      give_q       <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
`ifdef HT_LTF_SEQ_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      letsgo_q <= 1'b0;
      give_q   <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            nm1_q    <= nltf_to_nm1(n_ltf);
            err_q    <= !nltf_legal(n_ltf);
            letsgo_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= StReq;
`ifdef HT_LTF_SEQ_TIMEOUT_EN
            tmo_q    <= '0;
`endif
          end
        end
        StReq: begin
          if (gen_output_valid) begin
            give_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StFetch;
          end
`ifdef HT_LTF_SEQ_TIMEOUT_EN
          else if (tmo_q == TmoLast) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
`endif
        end
        StFetch: begin
          // Capture runs purely by count from the readout pulse.
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CapLast) begin
            rep_q        <= '0;
            rd_addr_q    <= '0;
            issue_done_q <= 1'b0;
            v1_q         <= 1'b0;
            state_q      <= StPlay;
          end
        end
        StPlay: begin
          if (rd_en) begin
            tvalid_q <= v1_q;
            tdata_q  <= v1_q ? apply_sign(rd_data, PRow[rep1_q]) : '0;
            tlast_q  <= v1_q & last1_q;
            v1_q     <= !issue_done_q;
            if (!issue_done_q) begin
              rep1_q  <= rep_q;
              last1_q <= issue_last;
              if (issue_last) begin
                issue_done_q <= 1'b1;
              end
              if (rd_addr_q == AddrLast) begin
                rd_addr_q <= '0;
                rep_q     <= rep_q + 2'd1;
              end else begin
                rd_addr_q <= rd_addr_q + AddrW'(1);
              end
            end
          end
          if (tvalid_q && m.tready && tlast_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          // Holding here for the done cycle makes a coincident start fall outside IDLE.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign gen_letsgo       = letsgo_q;
  assign gen_givemeoutput = give_q;
  assign m.tdata          = tdata_q;
  assign m.tvalid         = tvalid_q;
  assign m.tlast          = tlast_q;

endmodule

// File: tb/tb_ht_ltf_sequencer.sv
// tb_ht_ltf_sequencer: directed sequences with randomized data/backpressure against an
// integer-arithmetic model of the replayed HT-LTF stream.
module tb_ht_ltf_sequencer;

  localparam int SymLen = 80;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  n_ltf = 3'd0;
  logic        busy, done, err, gen_letsgo, gen_givemeoutput;
  logic        gen_output_valid = 1'b0;
  logic [31:0] gen_ltf = 32'h0;

  ht_ltf_sequencer_if m_if ();

  ht_ltf_sequencer dut (
    .clk              (clk),
    .rstn             (rstn),
    .start            (start),
    .n_ltf            (n_ltf),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .gen_letsgo       (gen_letsgo),
    .gen_givemeoutput (gen_givemeoutput),
    .gen_output_valid (gen_output_valid),
    .gen_ltf          (gen_ltf),
    .m                (m_if)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          gen_delay = 1;
  logic [31:0] sym_tx [SymLen];
  logic [31:0] got [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: repetition 1 negates both halves, clipping +32768 to +32767.
  function automatic logic [15:0] ref_neg(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    v = -v;
    if (v > 32767) v = 32767;
    return v[15:0];
  endfunction

  function automatic logic [31:0] exp_beat(input int b);
    int r;
    int k;
    logic [31:0] s;
    r = b / SymLen;
    k = b % SymLen;
    s = sym_tx[k];
    if (r != 1) return s;
    return {ref_neg(s[31:16]), ref_neg(s[15:0])};
  endfunction

  // Generator model: valid gen_delay cycles after gen_letsgo, symbol words start two
  // cycles after the gen_givemeoutput pulse; random junk outside the capture window.
  initial begin
    forever begin
      @(negedge clk);
      gen_ltf = $urandom;
      if (gen_letsgo === 1'b1) begin
        repeat (gen_delay) begin
          @(negedge clk);
          gen_ltf = $urandom;
        end
        gen_output_valid = 1'b1;
        for (int w = 0; w < 64 && gen_givemeoutput !== 1'b1; w++) @(negedge clk);
        gen_output_valid = 1'b0;
        @(negedge clk);
        gen_ltf = $urandom;
        @(negedge clk);
        gen_ltf = sym_tx[0];
        for (int k = 1; k < SymLen; k++) begin
          @(negedge clk);
          gen_ltf = sym_tx[k];
        end
      end
    end
  end

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, {31'h0, busy}, 32'h0);
    check({pfx, "_done"}, {31'h0, done}, 32'h0);
    check({pfx, "_err"}, {31'h0, err}, 32'h0);
    check({pfx, "_letsgo"}, {31'h0, gen_letsgo}, 32'h0);
    check({pfx, "_give"}, {31'h0, gen_givemeoutput}, 32'h0);
    check({pfx, "_tvalid"}, {31'h0, m_if.tvalid}, 32'h0);
    check({pfx, "_tlast"}, {31'h0, m_if.tlast}, 32'h0);
    check({pfx, "_tdata"}, m_if.tdata, 32'h0);
  endtask

  task automatic run_seq(input logic [2:0] n_req, input int delay, input bit rnd_ready,
                         input bit poke_start, input int abort_at);
    bit          legal;
    int          total;
    int          budget;
    int          first_cyc;
    int          last_cyc;
    bit          stalled, early_done, stab_bad, last_bad, finished, aborted;
    logic [31:0] held_d;
    logic        held_l;

    legal  = (n_req == 3'd1) || (n_req == 3'd2) || (n_req == 3'd4);
    total  = (legal ? int'(n_req) : 1) * SymLen;
    budget = delay + 4 * total + 400;
    gen_delay = delay;
    got.delete();
    first_cyc = -1;
    last_cyc = -2;
    stalled = 0; early_done = 0; stab_bad = 0; last_bad = 0; finished = 0; aborted = 0;
    held_d = '0;
    held_l = 1'b0;

    @(negedge clk);
    start = 1'b1;
    n_ltf = n_req;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'h0, busy}, 32'h1);
    check("letsgo_pulse", {31'h0, gen_letsgo}, 32'h1);
    check("err_after_start", {31'h0, err}, {31'h0, !legal});

    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      if (done === 1'b1) early_done = 1;
      if (stalled && (m_if.tvalid !== 1'b1 || m_if.tdata !== held_d || m_if.tlast !== held_l))
        stab_bad = 1;
      m_if.tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (poke_start && got.size() == 10) begin
        start = 1'b1;
        n_ltf = 3'd4;
      end else begin
        start = 1'b0;
      end
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
        if (got.size() == 0) first_cyc = cyc;
        last_cyc = cyc;
        if (m_if.tlast !== (got.size() == total - 1)) last_bad = 1;
        got.push_back(m_if.tdata);
        if (got.size() == total) finished = 1;
        stalled = 0;
      end else begin
        stalled = (m_if.tvalid === 1'b1);
        held_d  = m_if.tdata;
        held_l  = m_if.tlast;
      end
      if (abort_at > 0 && got.size() == abort_at) begin
        rstn = 1'b0;
        #1;
        check_all_zero("abort");
        aborted = 1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;

    for (int i = 0; i < got.size() && i < total; i++)
      check($sformatf("beat%0d", i), got[i], exp_beat(i));
    check("stall_stable", {31'h0, stab_bad}, 32'h0);
    check("no_early_done", {31'h0, early_done}, 32'h0);
    if (aborted) return;

    check("beat_count", got.size(), total);
    check("tlast_position", {31'h0, last_bad}, 32'h0);
    if (!rnd_ready) check("zero_bubble", last_cyc - first_cyc + 1, total);
    // Cycle after the final beat.
    check("done_pulse", {31'h0, done}, 32'h1);
    check("busy_clear", {31'h0, busy}, 32'h0);
    check("err_final", {31'h0, err}, {31'h0, !legal});
    start = 1'b1;
    n_ltf = 3'd2;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", {31'h0, done}, 32'h0);
    check("start_on_done_busy", {31'h0, busy}, 32'h0);
    check("start_on_done_letsgo", {31'h0, gen_letsgo}, 32'h0);
    check("tvalid_after_seq", {31'h0, m_if.tvalid}, 32'h0);
  endtask

  initial begin
    m_if.tready = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Ramp symbol, single repetition, long generator latency.
    for (int k = 0; k < SymLen; k++) sym_tx[k] = k;
    run_seq(3'd1, 300, 1'b0, 1'b0, -1);

    // Saturation corner in repetition 1.
    for (int k = 0; k < SymLen; k++) sym_tx[k] = $urandom;
    sym_tx[5] = 32'h8000_0001;
    run_seq(3'd2, 7, 1'b0, 1'b0, -1);
    check("beat85_sat", (got.size() > 85) ? got[85] : 32'hdead_dead, 32'h7fff_ffff);
    check("beat5_plain", (got.size() > 5) ? got[5] : 32'hdead_dead, 32'h8000_0001);

    // Four repetitions under random backpressure.
    for (int k = 0; k < SymLen; k++) sym_tx[k] = $urandom;
    sym_tx[7] = 32'h8000_8000;
    run_seq(3'd4, 12, 1'b1, 1'b0, -1);

    // Illegal count plus a start while busy.
    for (int k = 0; k < SymLen; k++) sym_tx[k] = $urandom;
    run_seq(3'd3, 4, 1'b0, 1'b1, -1);

    // Reset mid-PLAY, then a fresh sequence.
    for (int k = 0; k < SymLen; k++) sym_tx[k] = $urandom;
    run_seq(3'd4, 5, 1'b0, 1'b0, 40);
    repeat (2) @(negedge clk);
    check_all_zero("in_reset");
    rstn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < SymLen; k++) sym_tx[k] = $urandom;
    run_seq(3'd2, 9, 1'b1, 1'b0, -1);

    // A few random counts, including illegal ones.
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < SymLen; k++) sym_tx[k] = $urandom;
      run_seq(3'($urandom_range(0, 7)), $urandom_range(1, 20), 1'($urandom_range(0, 1)),
              1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
